// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, FSM state types and output address map
// for the FFT output reorder buffer. Macro: FFT_OUT_DIGITREV_EN.
package fft_pkg;

  localparam int NB    = 16;
  localparam int NPT   = 32;
  localparam int LANES = 4;
  localparam int BEATS = 8;
  localparam int AW    = 5;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } rd_state_t;

  // Bin k = k0 + 4*k1 + 16*k2 lands at 8*k0 + 2*k1 + k2.
  function automatic logic [AW-1:0] out_addr(
    input logic [AW-1:0] k
  );
`ifdef FFT_OUT_DIGITREV_EN
    return {k[1:0], k[3:2], k[4]};
`else
    return k;
`endif
  endfunction

endpackage

// File: rtl/fft_out_bank.sv
// fft_out_bank: two ping-pong banks of DEPTH x W samples.
// Ports: 4-lane beat write (wr_*), one synchronous read (rd_*).
module fft_out_bank
  import fft_pkg::*;
#(
  parameter int W     = 2 * NB,
  parameter int DEPTH = NPT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [LANES*AW-1:0] wr_addr,
  input  logic [LANES*W-1:0]  wr_data,
  input  logic                rd_en,
  input  logic                rd_bank,
  input  logic [AW-1:0]       rd_addr,
  output logic [W-1:0]        rd_data
);

  logic [W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem[{wr_bank, wr_addr[l*AW +: AW]}]
          <= wr_data[l*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: 8-beat x 4-lane FFT frames in, serial bins out.
// In: CLK, RST, IN_START, IN_R, IN_I, OUT_READY.
// Out: OUT_VALID, OUT_R, OUT_I, OUT_IDX, OUT_LAST, OVF.
// Macro FFT_OUT_DIGITREV_EN enables digit-reversed write order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int NB  = fft_pkg::NB,
  parameter int NPT = fft_pkg::NPT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_START,
  input  logic [NB*4-1:0] IN_R,
  input  logic [NB*4-1:0] IN_I,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [NB-1:0]   OUT_R,
  output logic [NB-1:0]   OUT_I,
  output logic [4:0]      OUT_IDX,
  output logic            OUT_LAST,
  output logic            OVF
);

  localparam int W  = 2 * NB;
  localparam int BW = $clog2(BEATS);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [BW-1:0] beat, beat_next, wr_beat;
  logic          wbank, wbank_next;
  logic          rbank, rbank_next;
  logic [1:0]    full, full_next;
  logic [AW-1:0] raddr, raddr_next;

  logic start_ok, start_bad, cont;
  logic accept, last_acc, free, fill_done;
  logic ready_r, ready_o, idle_go, step;
  logic wr_en, ld, ld_bank;
  logic [AW-1:0] ld_addr;

  logic [LANES*AW-1:0] wr_addr;
  logic [LANES*W-1:0]  wr_data;
  logic [W-1:0]        rd_data;

  assign accept   = (r_state == R_STREAM) && OUT_READY;
  assign last_acc = accept && (raddr == AW'(NPT - 1));

  // A bank released by the final accept may be refilled at once.
  assign free = !full[wbank] || (last_acc && (rbank == wbank));

  assign start_ok  = IN_START && ((w_state == W_FILL) || free);
  assign start_bad = IN_START && !start_ok;
  assign cont      = !IN_START && (w_state == W_FILL);

  always_comb begin
    w_next     = w_state;
    beat_next  = beat;
    wbank_next = wbank;
    wr_beat    = beat;
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    OVF        = 1'b0;
    unique case (1'b1)
      start_ok: begin
        wr_beat   = '0;
        wr_en     = 1'b1;
        beat_next = BW'(1);
        w_next    = W_FILL;
      end
      start_bad: begin
        OVF = 1'b1;
      end
      cont: begin
        wr_en     = 1'b1;
        beat_next = beat + 1'b1;
        if (beat == BW'(BEATS - 1)) begin
          fill_done  = 1'b1;
          w_next     = W_IDLE;
          wbank_next = ~wbank;
        end
      end
      default: ;
    endcase
  end

  // A bank completing this cycle counts as full for the reader.
  assign ready_r = full[rbank]
                 || (fill_done && (wbank == rbank));
  assign ready_o = full[~rbank]
                 || (fill_done && (wbank == ~rbank));
  assign idle_go = (r_state == R_IDLE) && ready_r;
  assign step    = accept && !last_acc;

  always_comb begin
    r_next     = r_state;
    rbank_next = rbank;
    raddr_next = raddr;
    full_next  = full;
    ld         = 1'b0;
    ld_bank    = rbank;
    ld_addr    = raddr;
    if (fill_done) begin
      full_next[wbank] = 1'b1;
    end
    unique case (1'b1)
      idle_go: begin
        ld         = 1'b1;
        ld_addr    = '0;
        raddr_next = '0;
        r_next     = R_STREAM;
      end
      step: begin
        ld         = 1'b1;
        ld_addr    = raddr + 1'b1;
        raddr_next = raddr + 1'b1;
      end
      last_acc: begin
        full_next[rbank] = 1'b0;
        rbank_next       = ~rbank;
        raddr_next       = '0;
        if (ready_o) begin
          ld      = 1'b1;
          ld_bank = ~rbank;
          ld_addr = '0;
        end else begin
          r_next = R_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      beat    <= '0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      full    <= '0;
      raddr   <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      beat    <= beat_next;
      wbank   <= wbank_next;
      rbank   <= rbank_next;
      full    <= full_next;
      raddr   <= raddr_next;
    end
  end

  // Lane 0 sits in the MSBs of IN_R / IN_I; bin k = 4*beat + lane.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_addr[l*AW +: AW] =
        out_addr(AW'(int'(wr_beat) * LANES + l));
      wr_data[l*W +: W] = {
        IN_R[(LANES-1-l)*NB +: NB],
        IN_I[(LANES-1-l)*NB +: NB]
      };
    end
  end

  fft_out_bank #(
    .W     (W),
    .DEPTH (NPT)
  ) u_bank (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (wr_en),
    .wr_bank (wbank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (ld),
    .rd_bank (ld_bank),
    .rd_addr (ld_addr),
    .rd_data (rd_data)
  );

  assign OUT_VALID = (r_state == R_STREAM);
  assign OUT_IDX   = raddr;
  assign OUT_LAST  = OUT_VALID && (raddr == AW'(NPT - 1));
  assign OUT_R     = rd_data[W-1:NB];
  assign OUT_I     = rd_data[NB-1:0];

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: randomized frames against a bin-order model.
// Covers reset, latency, stall, overflow, restart, back to back.
module tb_fft_out_reorder;

  localparam int NB = 16;

  typedef struct packed {
    logic [4:0]    idx;
    logic [NB-1:0] r;
    logic [NB-1:0] i;
    logic          last;
  } smp_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            IN_START = 1'b0;
  logic [NB*4-1:0] IN_R = '0;
  logic [NB*4-1:0] IN_I = '0;
  logic            OUT_READY = 1'b0;
  logic            OUT_VALID;
  logic [NB-1:0]   OUT_R;
  logic [NB-1:0]   OUT_I;
  logic [4:0]      OUT_IDX;
  logic            OUT_LAST;
  logic            OVF;

  int vec = 0;
  int bad = 0;
  int ovf_cnt = 0;

  smp_t got_q[$];
  smp_t exp_q[$];
  logic [NB-1:0] fr_r[32];
  logic [NB-1:0] fr_i[32];

  fft_out_reorder #(.NB(NB), .NPT(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_START  (IN_START),
    .IN_R      (IN_R),
    .IN_I      (IN_I),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_R     (OUT_R),
    .OUT_I     (OUT_I),
    .OUT_IDX   (OUT_IDX),
    .OUT_LAST  (OUT_LAST),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  // Inputs change at posedge+1, so the negedge view is what the
  // next rising edge acts on.
  always @(negedge CLK) begin
    if (RST && OVF) ovf_cnt++;
    if (RST && OUT_VALID && OUT_READY)
      got_q.push_back({OUT_IDX, OUT_R, OUT_I, OUT_LAST});
  end

  function automatic int amap(int k);
`ifdef FFT_OUT_DIGITREV_EN
    return (k % 4) * 8 + ((k / 4) % 4) * 2 + k / 16;
`else
    return k;
`endif
  endfunction

  task automatic gen_frame(input bit ramp);
    for (int k = 0; k < 32; k++) begin
      fr_r[k] = ramp ? NB'(k) : NB'($urandom);
      fr_i[k] = NB'($urandom);
    end
  endtask

  task automatic expect_frame();
    smp_t s[32];
    for (int k = 0; k < 32; k++) begin
      s[amap(k)].r = fr_r[k];
      s[amap(k)].i = fr_i[k];
    end
    for (int a = 0; a < 32; a++) begin
      s[a].idx  = 5'(a);
      s[a].last = (a == 31);
      exp_q.push_back(s[a]);
    end
  endtask

  task automatic drive_beat(input int b, input logic st);
    IN_START = st;
    for (int l = 0; l < 4; l++) begin
      IN_R[(3-l)*NB +: NB] = fr_r[4*b+l];
      IN_I[(3-l)*NB +: NB] = fr_i[4*b+l];
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    IN_START = 1'b0;
  endtask

  task automatic send_frame(input int nb, output logic ovf0);
    ovf0 = 1'b0;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, b == 0);
      #1;
      if (b == 0) ovf0 = OVF;
      tick();
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int c = 0; c < budget && got_q.size() < n; c++)
      tick();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    IN_START = 1'b1;
    OUT_READY = 1'b1;
    repeat (3) tick();
    IN_START = 1'b1;
    #1;
    vec++;
    if ({OUT_VALID, OUT_LAST, OVF} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000",
               {OUT_VALID, OUT_LAST, OVF});
    end
    vec++;
    if ({OUT_IDX, OUT_R, OUT_I} !== '0) begin
      bad++;
      $display("FAIL reset_data idx=%0d r=%h i=%h exp all 0",
               OUT_IDX, OUT_R, OUT_I);
    end
    IN_START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_single();
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b1;
    gen_frame(1'b1);
    expect_frame();
    for (int b = 0; b < 8; b++) begin
      drive_beat(b, b == 0);
      tick();
      vec++;
      if (OUT_VALID !== (b == 7)) begin
        bad++;
        $display("FAIL single_latency beat=%0d valid=%b exp=%b",
                 b, OUT_VALID, b == 7);
      end
    end
    wait_got(32, 60);
    tick();
    vec++;
    if (got_q.size() != 32 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL single_count got=%0d valid=%b exp=32 valid=0",
               got_q.size(), OUT_VALID);
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL single_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  task automatic test_stall();
    logic o;
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b0;
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o);
    vec++;
    if (OUT_VALID !== 1'b1) begin
      bad++;
      $display("FAIL stall_valid got=%b exp=1", OUT_VALID);
    end
    for (int c = 0; c < 64; c++) begin
      logic [4:0] si;
      logic [NB-1:0] sr, sj;
      logic rdy;
      rdy = (c % 2) == 1;
      OUT_READY = rdy;
      si = OUT_IDX;
      sr = OUT_R;
      sj = OUT_I;
      tick();
      if (!rdy) begin
        vec++;
        if ({OUT_VALID, OUT_IDX, OUT_R, OUT_I}
            !== {1'b1, si, sr, sj}) begin
          bad++;
          $display("FAIL stall_hold c=%0d got=%h/%h/%h exp=%h/%h/%h",
                   c, OUT_IDX, OUT_R, OUT_I, si, sr, sj);
        end
      end
    end
    vec++;
    if (got_q.size() != 32 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL stall_64cyc got=%0d valid=%b exp=32 valid=0",
               got_q.size(), OUT_VALID);
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL stall_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  task automatic test_overflow();
    logic o1, o2, o3;
    int ov0;
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b0;
    ov0 = ovf_cnt;
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o1);
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o2);
    gen_frame(1'b0);
    send_frame(8, o3);
    vec++;
    if ({o1, o2, o3} !== 3'b001) begin
      bad++;
      $display("FAIL ovf_pulse got=%b exp=001", {o1, o2, o3});
    end
    OUT_READY = 1'b1;
    wait_got(64, 90);
    repeat (10) tick();
    vec++;
    if (got_q.size() != 64 || ovf_cnt - ov0 != 1) begin
      bad++;
      $display("FAIL ovf_count got=%0d ovf=%0d exp=64 ovf=1",
               got_q.size(), ovf_cnt - ov0);
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL ovf_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  task automatic test_restart();
    logic o;
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b1;
    gen_frame(1'b0);
    send_frame(4, o);
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o);
    wait_got(32, 60);
    repeat (5) tick();
    vec++;
    if (got_q.size() != 32) begin
      bad++;
      $display("FAIL restart_count got=%0d exp=32", got_q.size());
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL restart_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic o1, o2;
    int gaps;
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b0;
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o1);
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o2);
    gen_frame(1'b0);
    expect_frame();
    OUT_READY = 1'b1;
    gaps = 0;
    for (int c = 0; c < 96; c++) begin
      if (c >= 31 && c < 39) drive_beat(c - 31, c == 31);
      #1;
      if (OUT_VALID !== 1'b1) gaps++;
      if (c == 31) begin
        vec++;
        if ({OUT_IDX, OVF} !== {5'd31, 1'b0}) begin
          bad++;
          $display("FAIL b2b_claim idx=%0d ovf=%b exp idx=31 ovf=0",
                   OUT_IDX, OVF);
        end
      end
      tick();
    end
    vec++;
    if (gaps != 0 || OUT_VALID !== 1'b0 || {o1, o2} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_bubble gaps=%0d tail=%b ovf=%b exp 0/0/00",
               gaps, OUT_VALID, {o1, o2});
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL b2b_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic o;
    got_q.delete();
    exp_q.delete();
    OUT_READY = 1'b1;
    gen_frame(1'b0);
    send_frame(8, o);
    wait_got(10, 40);
    vec++;
    if (got_q.size() != 10 || OUT_IDX !== 5'd10) begin
      bad++;
      $display("FAIL rstmid_pos got=%0d idx=%0d exp=10 idx=10",
               got_q.size(), OUT_IDX);
    end
    RST = 1'b0;
    #1;
    vec++;
    if ({OUT_VALID, OUT_IDX, OUT_R, OUT_I} !== '0) begin
      bad++;
      $display("FAIL rstmid_clear valid=%b idx=%0d r=%h exp all 0",
               OUT_VALID, OUT_IDX, OUT_R);
    end
    tick();
    tick();
    RST = 1'b1;
    tick();
    got_q.delete();
    gen_frame(1'b0);
    expect_frame();
    send_frame(8, o);
    wait_got(32, 60);
    repeat (5) tick();
    vec++;
    if (got_q.size() != 32) begin
      bad++;
      $display("FAIL rstmid_count got=%0d exp=32", got_q.size());
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      smp_t g;
      g = (n < got_q.size()) ? got_q[n] : 'x;
      vec++;
      if (g !== exp_q[n]) begin
        bad++;
        $display("FAIL rstmid_data n=%0d got=%h exp=%h",
                 n, g, exp_q[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter NB, default 16, meaning bit width of one real or imaginary sample.
REQ-002 SHALL have parameter NPT, default 32, meaning FFT points per frame; only 32 is supported.
REQ-003 SHALL have port CLK  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port IN_START  input  1  one-cycle pulse marking beat 0 of an 8-beat input frame.
REQ-006 SHALL have port IN_R  input  NB*4  real parts of 4 lanes; lane 0 is in the MSBs.
REQ-007 SHALL have port IN_I  input  NB*4  imaginary parts of 4 lanes; same packing as IN_R.
REQ-008 SHALL have port OUT_VALID  output  1  serial output sample valid.
REQ-009 SHALL have port OUT_READY  input  1  downstream accepts the sample.
REQ-010 SHALL have port OUT_R / OUT_I  output  NB each  serial sample.
REQ-011 SHALL have port OUT_IDX  output  5  frequency index of the current sample.
REQ-012 SHALL have port OUT_LAST  output  1  high with OUT_IDX==31.
REQ-013 SHALL have port OVF  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-014 SHALL capture IN_R/IN_I on the IN_START cycle (beat 0) and on the 7 following cycles (beats 1..7), unconditionally.
REQ-015 SHALL compute k = 4*b + l for beat b and lane l, and SHALL write the sample to address a = 8*k0 + 2*k1 + k2, where k = k0 + 4*k1 + 16*k2.
REQ-016 SHALL use two banks (ping-pong): the writer fills one bank while the reader drains the other.
REQ-017 Writer FSM SHALL have states W_IDLE, W_FILL, with transitions:
- W_IDLE to W_FILL on IN_START with a free bank.
- W_FILL to W_IDLE after beat 7, marking the bank full.
REQ-018 SHALL restart beat counting at 0 when IN_START arrives during W_FILL; the partial bank is discarded and not marked full.
REQ-019 SHALL ignore IN_START when no bank is free, pulse OVF in the same cycle, and ignore the 7 following beats.
REQ-020 Reader FSM SHALL have states R_IDLE, R_STREAM, with transitions:
- R_IDLE to R_STREAM when a bank is full.
- R_STREAM advances the address on OUT_VALID && OUT_READY.
- After address 31 is accepted: to the other bank if it is full, else R_IDLE.
REQ-021 SHALL read addresses 0..31 in order, with OUT_IDX equal to the address.
REQ-022 SHALL assert OUT_VALID on the cycle after beat 7 is written when the reader is idle (latency 1 cycle).
REQ-023 SHALL keep OUT_R/OUT_I/OUT_IDX stable while OUT_VALID && !OUT_READY.
REQ-024 SHALL let a bank freed by acceptance of address 31 be claimed by an IN_START in that same cycle.
REQ-025 SHALL stream back to back with no bubble between frames when both banks are full.

Reset
REQ-026 SHALL, while RST is low:
- drive OUT_VALID=0, OUT_LAST=0, OVF=0, OUT_IDX=0, OUT_R=0, OUT_I=0;
- put both FSMs in idle, both banks empty, write bank 0, read bank 0.
REQ-027 SHALL abort any frame in progress on reset mid-operation; bank RAM contents are don't-care.

Configuration
REQ-028 With FFT_OUT_DIGITREV_EN defined, SHALL apply the REQ-015 address mapping.
REQ-029 Without FFT_OUT_DIGITREV_EN, SHALL write to address a = k (arrival order preserved); OUT_IDX SHALL still equal the address.

Structure
REQ-030 SHALL take NB, NPT, LANES=4, BEATS=8 and the digit-reverse address function from shared package fft_pkg.
REQ-031 SHALL place bank storage in sub-module fft_out_bank: two banks of 32 x 2*NB entries, 4 write ports for one beat, 1 synchronous read port.

Verification
REQ-032 Reset then one frame with lane value = 4*b+l, OUT_READY=1 -> OUT_VALID rises the cycle after beat 7; 32 samples follow with OUT_IDX 0..31 and the sample at OUT_IDX a equals the k that maps to a (e.g. a=8 gives k=1); OUT_LAST only at 31.
REQ-033 OUT_READY toggled 1/0 each cycle -> every sample is held stable while stalled; the frame completes in 64 cycles.
REQ-034 Three frames back to back, OUT_READY held 0 -> frames 1 and 2 are stored, frame 3 gives OVF pulse = 1; after release, exactly 64 samples from frames 1 and 2 are output.
REQ-035 IN_START reasserted at beat 4 -> the first partial frame is discarded; the output holds only the second frame's data.
REQ-036 RST low at output sample 10 -> OUT_VALID=0 at once; after release the next frame outputs cleanly from OUT_IDX 0.
REQ-037 Build without FFT_OUT_DIGITREV_EN, frame as in REQ-032 -> output data equals OUT_IDX for all 32 samples.
